systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder_if.sv | 27 ++
 rtl/systolic_feeder.sv | 112 +++++++++++
 tb/tb_systolic_feeder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Handshake and array-facing bus between the input buffer, the skew feeder
// and the systolic array rows.
interface systolic_feeder_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_SIZE  = 8,
  parameter int CNT_W      = 8
);
  logic                           start;
  logic [CNT_W-1:0]               num_rows;
  logic                           in_valid;
  logic                           in_ready;
  logic [ARRAY_SIZE*DATA_SIZE-1:0] in_data;
  logic [ARRAY_SIZE*DATA_SIZE-1:0] out_left;
  logic [ARRAY_SIZE-1:0]          go;
  logic                           busy;
  logic                           done;

  modport master (
    output start, num_rows, in_valid, in_data,
    input  in_ready, out_left, go, busy, done
  );

  modport slave (
    input  start, num_rows, in_valid, in_data,
    output in_ready, out_left, go, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Input skew feeder: accepts one activation vector per cycle and presents
// element i to array row i after i+1 register stages, with a matching go strobe.
module systolic_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_SIZE  = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int DRAIN_W = $clog2(ARRAY_SIZE);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   rows_q;
  logic [CNT_W-1:0]   accepted;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               hs;

  // in_ready_q is high exactly while in FEED, so it doubles as the state qualifier.
  assign hs = bus.in_valid & in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rows_q     <= '0;
      accepted   <= '0;
      drain_cnt  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.num_rows == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              rows_q     <= bus.num_rows;
              accepted   <= '0;
              in_ready_q <= 1'b1;
              state      <= FEED;
            end
          end
        end
        FEED: begin
          if (hs) begin
            accepted <= accepted + CNT_W'(1);
            if (accepted + CNT_W'(1) == rows_q) begin
              in_ready_q <= 1'b0;
              drain_cnt  <= DRAIN_LAST;
              state      <= DRAIN;
            end
          end
        end
        // Hold for ARRAY_SIZE edges so the last element clears the deepest lane.
        DRAIN: begin
          if (drain_cnt == '0) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_SIZE-1:0] data_p [0:i];
    logic [i:0]           vld_p;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) data_p[k] <= '0;
        vld_p <= '0;
      end else begin
        // Stage 0: a FEED cycle without a handshake injects a bubble.
        data_p[0] <= hs ? bus.in_data[i*DATA_SIZE +: DATA_SIZE] : '0;
        vld_p[0]  <= hs;
        // Stages 1..i: plain delay line.
        for (int k = 1; k <= i; k++) begin
          data_p[k] <= data_p[k-1];
          vld_p[k]  <= vld_p[k-1];
        end
      end
    end

    assign bus.out_left[i*DATA_SIZE +: DATA_SIZE] = data_p[i];
    assign bus.go[i]                              = vld_p[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: each accepted vector queues one
// expected (cycle, element) entry per lane; the lanes are compared every cycle.
module tb_systolic_feeder;

  localparam int A = 4;
  localparam int D = 8;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.ARRAY_SIZE(A), .DATA_SIZE(D), .CNT_W(C)) bus ();

  systolic_feeder #(.ARRAY_SIZE(A), .DATA_SIZE(D), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference state derived from the documented timing
  logic exp_ready = 1'b0;
  logic exp_busy  = 1'b0;
  int   done_at   = -100;
  int   left      = 0;
  logic last_hs   = 1'b0;

  int           due_q [A][$];
  logic [D-1:0] dat_q [A][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [A*D-1:0] vec(input int base, input int k);
    logic [A*D-1:0] v;
    for (int i = 0; i < A; i++) v[i*D +: D] = D'(base + 4*k + i + 1);
    return v;
  endfunction

  task automatic check_outputs();
    logic         eg;
    logic [D-1:0] ed;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("busy",     32'(bus.busy),     32'(exp_busy));
    check("done",     32'(bus.done),     32'(exp_busy && cyc == done_at));
    for (int i = 0; i < A; i++) begin
      eg = 1'b0;
      ed = '0;
      if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
        eg = 1'b1;
        ed = dat_q[i].pop_front();
        void'(due_q[i].pop_front());
      end
      check($sformatf("go%0d", i),   32'(bus.go[i]), 32'(eg));
      check($sformatf("lane%0d", i), 32'(bus.out_left[i*D +: D]), 32'(ed));
    end
  endtask

  // One clock: inputs are already driven; update reference on the edge, check at negedge.
  task automatic tick();
    logic idle_b;
    logic hs;
    logic st;
    logic [C-1:0] nr;
    logic [A*D-1:0] dv;
    idle_b = !exp_busy;
    hs     = bus.in_valid && exp_ready && !rst;
    st     = bus.start && !rst;
    nr     = bus.num_rows;
    dv     = bus.in_data;
    @(posedge clk);
    cyc++;
    last_hs = hs;
    if (!rst) begin
      if (exp_busy && done_at == cyc - 1) exp_busy = 1'b0;
      if (hs) begin
        for (int i = 0; i < A; i++) begin
          due_q[i].push_back(cyc + i);
          dat_q[i].push_back(dv[i*D +: D]);
        end
        left--;
        if (left == 0) begin
          exp_ready = 1'b0;
          done_at   = cyc + A;
        end
      end
      if (st && idle_b) begin
        exp_busy = 1'b1;
        if (nr == '0) done_at = cyc;
        else begin
          left      = int'(nr);
          exp_ready = 1'b1;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Run a job; optional bubbles after vector 0 and an ignored start pulse mid-feed.
  task automatic run_job(input int n, input int base, input int gap, input bit restart);
    int k;
    int bub;
    int guard;
    bit pulsed;
    k = 0; bub = 0; guard = 0; pulsed = 0;
    bus.num_rows = C'(n);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    while (k < n && guard < 50) begin
      if (k == 1 && bub < gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bub++;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = vec(base, k);
      end
      if (restart && k == 1 && !pulsed) begin
        bus.start    = 1'b1;
        bus.num_rows = C'(n + 2);
        pulsed       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (last_hs) k++;
      guard++;
    end
    if (guard >= 50) check("job_timeout", 32'(k), 32'(n));
    bus.start = 1'b0;
    // Back-pressure: valid stays high with junk through DRAIN, DONE and IDLE
    bus.in_valid = 1'b1;
    bus.in_data  = {A{8'hEE}};
    for (int t = 0; t < A + 3; t++) tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_go",       32'(bus.go),       32'd0);
    check("rst_out_left", bus.out_left,      32'd0);
    exp_ready = 1'b0;
    exp_busy  = 1'b0;
    done_at   = -100;
    left      = 0;
    for (int i = 0; i < A; i++) begin
      due_q[i].delete();
      dat_q[i].delete();
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) tick();
  endtask

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.num_rows = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // Idle with valid asserted: must not be accepted
    bus.in_valid = 1'b1;
    bus.in_data  = {A{8'h55}};
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();

    run_job(3, 0, 0, 1'b0);   // back-to-back diagonal 1..12
    run_job(3, 0, 2, 1'b0);   // two bubbles between vectors 1 and 2
    run_job(0, 0, 0, 1'b0);   // zero-length job
    run_job(3, 100, 0, 1'b1); // start pulse mid-feed is ignored

    // Reset after two of three vectors accepted
    bus.num_rows = C'(3);
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (k < 2 && cyc < 500) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec(40, k);
      tick();
      if (last_hs) k++;
    end
    async_reset();

    run_job(1, 200, 0, 1'b0); // minimum job after reset
    tick();

    begin
      int pend;
      pend = 0;
      for (int i = 0; i < A; i++) pend += due_q[i].size();
      check("lanes_drained", 32'(pend), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
